// File: rtl/if_stage_pkg.sv
// Shared constants and types for the instruction-fetch stage.
// The address-range check is built only when IF_ADDR_CHECK_EN is defined.
package if_stage_pkg;

  localparam logic [31:0] PcReset = 32'h0000_3000;
  localparam logic [31:0] TextLo  = 32'h0000_3000;
  localparam logic [31:0] TextHi  = 32'h0000_6FFC;
  localparam logic [31:0] Nop     = 32'h0000_0000;

  typedef enum logic [1:0] {
    StFetch = 2'd0,
    StWait  = 2'd1,
    StHold  = 2'd2
  } state_e;

  // True when pc is word-aligned and inside the text segment.
  function automatic logic addr_ok(input logic [31:0] pc);
    return (pc[1:0] == 2'b00) && (pc >= TextLo) && (pc <= TextHi);
  endfunction

endpackage

// File: rtl/if_stage_if.sv
// Instruction-memory request/response bundle between the fetch stage and memory.
interface if_stage_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        imem_ready;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_rdata,
    input  imem_ready
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_rdata,
    output imem_ready
  );
endinterface

// File: rtl/if_stage_pc_reg.sv
// Fetch PC register: async reset to the boot address, enable, and npc/target select.
module if_stage_pc_reg
  import if_stage_pkg::*;
(
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        en_i,
  input  logic        sel_target_i,
  input  logic [31:0] npc_i,
  input  logic [31:0] target_i,
  output logic [31:0] pc_o
);

  logic [31:0] pc_d, pc_q;

  always_comb begin
    pc_d = sel_target_i ? target_i : npc_i;
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      pc_q <= PcReset;
    end else if (en_i) begin
      pc_q <= pc_d;
    end
  end

  assign pc_o = pc_q;

endmodule

// File: rtl/if_stage.sv
// Instruction-fetch stage: fetch FSM, IF/ID pipeline register and PC register.
// Optional fetch-address checking is enabled by defining IF_ADDR_CHECK_EN.
module if_stage
  import if_stage_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic [31:0]       npc,
  input  logic              stall,
  if_stage_if.master        imem,
  output logic [31:0]       pcIF,
  output logic [31:0]       pcID,
  output logic [31:0]       instrID,
  output logic              validID,
  output logic              excID
);

  state_e      state_d, state_q;
  logic [31:0] target_d, target_q;
  logic [31:0] buf_d, buf_q;
  logic [31:0] pcid_q, instr_q;
  logic        valid_q, exc_q;

  logic        pc_en, pc_sel_target;
  logic        id_load;
  logic [31:0] id_pc, id_instr;
  logic        id_valid, id_exc;
  logic        req;
  logic        addr_err;

`ifdef IF_ADDR_CHECK_EN
  assign addr_err = ~addr_ok(pcIF);
`else
  assign addr_err = 1'b0;
`endif

  if_stage_pc_reg u_pc_reg (
    .clk_i        (clk),
    .reset_i      (reset),
    .en_i         (pc_en),
    .sel_target_i (pc_sel_target),
    .npc_i        (npc),
    .target_i     (target_q),
    .pc_o         (pcIF)
  );

  always_comb begin
    state_d       = state_q;
    target_d      = target_q;
    buf_d         = buf_q;
    pc_en         = 1'b0;
    pc_sel_target = 1'b0;
    id_load       = 1'b0;
    id_pc         = pcIF;
    id_instr      = imem.imem_rdata;
    id_valid      = 1'b1;
    id_exc        = 1'b0;
    req           = 1'b0;

    unique case (state_q)
      StFetch: begin
        req = ~addr_err;
        if (!stall) begin
          if (addr_err) begin
            id_load  = 1'b1;
            id_instr = Nop;
            id_exc   = 1'b1;
            pc_en    = 1'b1;
          end else if (imem.imem_ready) begin
            id_load = 1'b1;
            pc_en   = 1'b1;
          end else begin
            // Latch npc now: the redirect from the instruction leaving ID is gone next cycle.
            target_d = npc;
            id_load  = 1'b1;
            id_pc    = pcid_q;
            id_instr = Nop;
            id_valid = 1'b0;
            state_d  = StWait;
          end
        end
      end
      StWait: begin
        req = 1'b1;
        if (imem.imem_ready) begin
          if (!stall) begin
            id_load       = 1'b1;
            pc_en         = 1'b1;
            pc_sel_target = 1'b1;
            state_d       = StFetch;
          end else begin
            buf_d   = imem.imem_rdata;
            state_d = StHold;
          end
        end
      end
      StHold: begin
        if (!stall) begin
          id_load       = 1'b1;
          id_instr      = buf_q;
          pc_en         = 1'b1;
          pc_sel_target = 1'b1;
          state_d       = StFetch;
        end
      end
      default: state_d = StFetch;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= StFetch;
      target_q <= '0;
      buf_q    <= '0;
    end else begin
      state_q  <= state_d;
      target_q <= target_d;
      buf_q    <= buf_d;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pcid_q  <= PcReset;
      instr_q <= Nop;
      valid_q <= 1'b0;
      exc_q   <= 1'b0;
    end else if (id_load) begin
      pcid_q  <= id_pc;
      instr_q <= id_instr;
      valid_q <= id_valid;
      exc_q   <= id_exc;
    end
  end

  // Gate with reset so no request leaks out while the stage is being cleared.
  assign imem.imem_req  = req & ~reset;
  assign imem.imem_addr = pcIF;
  assign pcID           = pcid_q;
  assign instrID        = instr_q;
  assign validID        = valid_q;
  assign excID          = exc_q;

endmodule

// File: tb/tb_if_stage.sv
// Self-checking bench for if_stage: directed scenarios followed by random traffic
// checked against a transaction-level model of the fetch stage.
module tb_if_stage;

  logic        clk;
  logic        reset;
  logic [31:0] npc;
  logic        stall;
  logic [31:0] pcIF, pcID, instrID;
  logic        validID, excID;

  if_stage_if imem_bus ();

  if_stage dut (
    .clk     (clk),
    .reset   (reset),
    .npc     (npc),
    .stall   (stall),
    .imem    (imem_bus),
    .pcIF    (pcIF),
    .pcID    (pcID),
    .instrID (instrID),
    .validID (validID),
    .excID   (excID)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Model: a fetch is either idle (issuing at m_pc), waiting on memory, or holding a word.
  logic [31:0] m_pc, m_pcid, m_instr, m_target, m_buf;
  logic        m_valid, m_exc, m_waiting, m_held;

  function automatic logic m_bad(input logic [31:0] pc);
`ifdef IF_ADDR_CHECK_EN
    return !((pc % 4 == 0) && pc >= 32'h3000 && pc <= 32'h6FFC);
`else
    return 1'b0;
`endif
  endfunction

  function automatic logic m_req();
    if (m_held) return 1'b0;
    if (!m_waiting && m_bad(m_pc)) return 1'b0;
    return 1'b1;
  endfunction

  task automatic m_reset();
    m_pc = 32'h3000; m_pcid = 32'h3000; m_instr = 0; m_valid = 0; m_exc = 0;
    m_target = 0; m_buf = 0; m_waiting = 0; m_held = 0;
  endtask

  task automatic m_deliver(input logic [31:0] pc, input logic [31:0] word, input logic exc);
    m_pcid = pc; m_instr = word; m_valid = 1; m_exc = exc;
  endtask

  task automatic m_step(input logic [31:0] n, input logic s, input logic rdy,
                        input logic [31:0] rd);
    if (m_held) begin
      if (!s) begin
        m_deliver(m_pc, m_buf, 0); m_pc = m_target; m_held = 0;
      end
    end else if (m_waiting) begin
      if (rdy && !s) begin
        m_deliver(m_pc, rd, 0); m_pc = m_target; m_waiting = 0;
      end else if (rdy) begin
        m_buf = rd; m_held = 1; m_waiting = 0;
      end
    end else if (!s) begin
      if (m_bad(m_pc)) begin
        m_deliver(m_pc, 0, 1); m_pc = n;
      end else if (rdy) begin
        m_deliver(m_pc, rd, 0); m_pc = n;
      end else begin
        m_target = n; m_instr = 0; m_valid = 0; m_exc = 0; m_waiting = 1;
      end
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
    end
  endtask

  task automatic chk_regs(input string tag);
    chk({tag, ".pcIF"}, pcIF, m_pc);
    chk({tag, ".pcID"}, pcID, m_pcid);
    chk({tag, ".instrID"}, instrID, m_instr);
    chk({tag, ".validID"}, {31'b0, validID}, {31'b0, m_valid});
    chk({tag, ".excID"}, {31'b0, excID}, {31'b0, m_exc});
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, ".req"}, {31'b0, imem_bus.imem_req}, 32'd0);
    chk({tag, ".pcIF"}, pcIF, 32'h3000);
    chk({tag, ".pcID"}, pcID, 32'h3000);
    chk({tag, ".instrID"}, instrID, 32'h0);
    chk({tag, ".validID"}, {31'b0, validID}, 32'd0);
    chk({tag, ".excID"}, {31'b0, excID}, 32'd0);
  endtask

  // One clock: drive, check request side, clock, check IF/ID side.
  task automatic cycle(input logic [31:0] n, input logic s, input logic rdy,
                       input logic [31:0] rd);
    npc = n; stall = s; imem_bus.imem_ready = rdy; imem_bus.imem_rdata = rd;
    #1;
    chk("req", {31'b0, imem_bus.imem_req}, {31'b0, m_req()});
    if (m_req()) chk("addr", imem_bus.imem_addr, m_pc);
    @(posedge clk);
    m_step(n, s, rdy, rd);
    #1;
    chk_regs("cyc");
  endtask

  // Asynchronous reset pulse; a ready arriving under reset must be ignored.
  task automatic pulse_reset();
    imem_bus.imem_ready = 1'b0;
    reset = 1'b1;
    #1;
    chk_reset_vals("rst_async");
    imem_bus.imem_ready = 1'b1;
    imem_bus.imem_rdata = 32'hBAD0_BAD0;
    @(posedge clk);
    #1;
    chk_reset_vals("rst_held");
    reset = 1'b0;
    imem_bus.imem_ready = 1'b0;
    m_reset();
  endtask

  logic [31:0] n_rand;

  initial begin
    reset = 1'b1; npc = 0; stall = 0;
    imem_bus.imem_ready = 0; imem_bus.imem_rdata = 0;
    m_reset();
    #1;
    chk("req_in_reset", {31'b0, imem_bus.imem_req}, 32'd0);
    @(posedge clk); @(posedge clk); #1;
    chk_reset_vals("reset");
    reset = 1'b0;

    // Straight-line fetch, one word per cycle.
    #1;
    chk("first_addr", imem_bus.imem_addr, 32'h3000);
    cycle(m_pc + 4, 0, 1, 32'h1111_0001);
    chk("seq_pcID0", pcID, 32'h3000);
    chk("seq_valid0", {31'b0, validID}, 32'd1);
    chk("seq_addr1", imem_bus.imem_addr, 32'h3004);
    cycle(m_pc + 4, 0, 1, 32'h1111_0002);
    chk("seq_addr2", imem_bus.imem_addr, 32'h3008);
    cycle(m_pc + 4, 0, 1, 32'h1111_0003);

    // Wait states while a branch in ID redirects to 0x3040.
    pulse_reset();
    cycle(32'h3004, 0, 1, 32'h1000_000F);
    cycle(32'h3040, 0, 0, 32'hDEAD_0000);
    chk("ws_bubble1", {31'b0, validID}, 32'd0);
    cycle(32'h5550, 0, 0, 32'hDEAD_0001);
    cycle(32'h5554, 1, 0, 32'hDEAD_0002);
    chk("ws_bubble3", {31'b0, validID}, 32'd0);
    cycle(32'h5558, 0, 1, 32'h2222_0004);
    chk("ws_ds_pc", pcID, 32'h3004);
    chk("ws_ds_instr", instrID, 32'h2222_0004);
    chk("ws_redirect", imem_bus.imem_addr, 32'h3040);

    // Stall in FETCH.
    cycle(32'h3010, 0, 1, 32'h3333_0040);
    cycle(32'h3014, 1, 1, 32'hDEAD_0003);
    cycle(32'h3014, 1, 1, 32'hDEAD_0004);
    chk("stall_pc", pcIF, 32'h3010);
    chk("stall_instr", instrID, 32'h3333_0040);
    cycle(32'h3014, 0, 1, 32'h3333_0010);
    chk("stall_resume", instrID, 32'h3333_0010);

    // Word returns during stall: hold it, then release.
    cycle(32'h3080, 0, 0, 32'hDEAD_0005);
    cycle(32'h4000, 1, 1, 32'h4444_0014);
    cycle(32'h4004, 1, 0, 32'hDEAD_0006);
    chk("hold_req", {31'b0, imem_bus.imem_req}, 32'd0);
    cycle(32'h4008, 0, 0, 32'hDEAD_0007);
    chk("hold_instr", instrID, 32'h4444_0014);
    chk("hold_pcID", pcID, 32'h3014);
    chk("hold_target", pcIF, 32'h3080);

    // Reset in the middle of a wait.
    cycle(32'h3090, 0, 0, 32'hDEAD_0008);
    pulse_reset();
    #1;
    chk("post_rst_req", {31'b0, imem_bus.imem_req}, 32'd1);
    chk("post_rst_addr", imem_bus.imem_addr, 32'h3000);

`ifdef IF_ADDR_CHECK_EN
    cycle(32'h3002, 0, 1, 32'h5555_0000);
    cycle(32'h3008, 0, 1, 32'hDEAD_0009);
    chk("exc_pcID", pcID, 32'h3002);
    chk("exc_instr", instrID, 32'h0);
    chk("exc_valid", {31'b0, validID}, 32'd1);
    chk("exc_flag", {31'b0, excID}, 32'd1);
`endif

    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 99) == 0) pulse_reset();
      case ($urandom_range(0, 9))
        0, 1:    n_rand = 32'h3000 + 4 * $urandom_range(0, 32'hFFF);
`ifdef IF_ADDR_CHECK_EN
        2:       n_rand = m_pc + 2;
        3:       n_rand = 32'h7000 + 4 * $urandom_range(0, 15);
`endif
        default: n_rand = m_pc + 4;
      endcase
      cycle(n_rand, ($urandom_range(0, 3) == 0), ($urandom_range(0, 2) != 0), $urandom);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/if_stage.md
IF_STAGE -- requirements
Module: if_stage

Interface
REQ-001 SHALL have port: clk  in  1  single clock; all state updates on its rising edge.
REQ-002 SHALL have port: reset  in  1  asynchronous, active-high; clears all state immediately.
REQ-003 SHALL have port: npc  in  32  next PC from the NPC block, valid every cycle.
REQ-004 SHALL have port: stall  in  1  hazard-unit freeze of PC and IF/ID.
REQ-005 SHALL have port: imem_req  out  1  instruction-memory request.
REQ-006 SHALL have port: imem_addr  out  32  fetch address, equal to pcIF.
REQ-007 SHALL have port: imem_rdata  in  32  instruction word, valid when imem_ready=1.
REQ-008 SHALL have port: imem_ready  in  1  fetch complete this cycle; may be 0 for wait states.
REQ-009 SHALL have port: pcIF  out  32  current fetch PC, fed to NPC.
REQ-010 SHALL have ports: pcID / instrID  out  32 each  IF/ID register contents, fed to NPC and decode.
REQ-011 SHALL have port: validID  out  1  IF/ID holds a real instruction; 0 means bubble.
REQ-012 SHALL have port: excID  out  1  fetch address-error flag for the IF/ID instruction.

Function
REQ-013 SHALL implement FSM states FETCH, WAIT, HOLD.
REQ-014 SHALL drive imem_req=1 in FETCH and WAIT, and imem_req=0 in HOLD.
REQ-015 FETCH with stall=1 SHALL hold pcIF and IF/ID, stay in FETCH, and ignore imem_ready.
REQ-016 FETCH with stall=0 and imem_ready=1 SHALL load IF/ID with {pcIF, imem_rdata, valid=1} and set pcIF<=npc, giving 1-cycle latency.
REQ-017 FETCH with stall=0 and imem_ready=0 SHALL capture target_q<=npc, load an IF/ID bubble {pcID held, instr=0, valid=0}, hold pcIF, and go to WAIT.
REQ-018 In WAIT and HOLD, npc SHALL be ignored; target_q preserves any branch/jump redirect resolved by the instruction that left ID.
REQ-019 WAIT with imem_ready=1 and stall=0 SHALL load IF/ID with {pcIF, imem_rdata, 1}, set pcIF<=target_q, and go to FETCH.
REQ-020 WAIT with imem_ready=1 and stall=1 SHALL capture instr_buf<=imem_rdata and go to HOLD; IF/ID and pcIF hold.
REQ-021 WAIT with imem_ready=0 SHALL hold pcIF, target_q, and IF/ID (the bubble stays valid=0 regardless of stall).
REQ-022 HOLD with stall=0 SHALL load IF/ID with {pcIF, instr_buf, 1}, set pcIF<=target_q, and go to FETCH; HOLD with stall=1 SHALL hold everything.
REQ-023 PC arithmetic SHALL be 32-bit, with wrap-around at 0xFFFF_FFFC left unguarded.

Reset
REQ-024 On reset SHALL set: pcIF=0x0000_3000, pcID=0x0000_3000, instrID=0, validID=0, excID=0, target_q=0, instr_buf=0, state=FETCH.
REQ-025 imem_req SHALL read 0 while reset=1; after reset release the first request SHALL be to 0x0000_3000.
REQ-026 Reset asserted in WAIT or HOLD SHALL abandon the outstanding fetch; an imem_ready arriving during or after reset SHALL be ignored until FETCH issues a fresh request.

Configuration
REQ-027 SHALL use macro IF_ADDR_CHECK_EN.
REQ-028 With IF_ADDR_CHECK_EN defined: in FETCH, if pcIF[1:0]!=0 or pcIF is outside 0x0000_3000..0x0000_6FFC, imem_req SHALL be 0 and, unless stall=1, IF/ID SHALL load {pcIF, 0, valid=1, excID=1} with pcIF<=npc.
REQ-029 Without IF_ADDR_CHECK_EN: no address check SHALL be performed and excID SHALL be constant 0.

Structure
REQ-030 define.v SHALL hold the shared constants: PC_RESET (32'h0000_3000), text-segment bounds, NOP (32'h0), and FSM state encodings.
REQ-031 SHALL contain one sub-module, pc_reg: PC register with async reset, enable, and next-value mux (npc/target_q).
REQ-032 The FSM and IF/ID register SHALL reside in if_stage.

Verification
REQ-033 Reset release, imem_ready=1 every cycle, npc=pcIF+4 -> imem_addr 0x3000, 0x3004, 0x3008; pcID lags by one cycle; validID=1 from cycle 2.
REQ-034 imem_ready=0 for 3 cycles at pcIF=0x3004 while ID holds beq with npc=0x3040 -> 3 bubbles (validID=0); delay slot 0x3004 enters ID; next imem_addr=0x3040.
REQ-035 stall=1 for 2 cycles in FETCH at pcIF=0x3010 -> pcIF and instrID unchanged; resumes with the 0x3010 word.
REQ-036 WAIT, imem_ready=1 with stall=1, stall released 2 cycles later -> imem_req=0 during HOLD; buffered word appears in instrID on release; pcIF<=target_q.
REQ-037 reset pulse mid-WAIT -> all outputs at reset values immediately; late imem_ready ignored; first post-reset request 0x3000.
REQ-038 IF_ADDR_CHECK_EN defined, npc=0x3002 -> no imem_req for 0x3002; IF/ID holds pcID=0x3002, instr 0, validID=1, excID=1.
